// File: rtl/epoch_counter.sv
// epoch_counter: run-time bounded wrap-around counter
// with a multi-bit epoch (wrap) count and wrap pulse.
module epoch_counter #(
    parameter int WIDTH   = 8,
    parameter int EPOCH_W = 1,
    parameter int STRIDE  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               srst,
    input  logic               en,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic               down,
    output logic [WIDTH-1:0]   count,
    output logic [EPOCH_W-1:0] epoch,
    output logic               phase,
    output logic               last,
    output logic               wrap,
    output logic               cfg_err
);

    localparam logic [WIDTH:0] LP_STRIDE = (WIDTH+1)'(STRIDE);

    logic [WIDTH-1:0]   r_count;
    logic [EPOCH_W-1:0] r_epoch;
    logic               r_wrap;

    logic [WIDTH:0]     w_cnt_x;
    logic [WIDTH:0]     w_hi_x;
    logic [WIDTH:0]     w_lo_x;
    logic [WIDTH:0]     w_up_sum;
    logic [WIDTH:0]     w_lo_sum;
    logic               w_last_up;
    logic               w_last_dn;
    logic               w_last;
    logic [WIDTH-1:0]   w_start;
    logic [WIDTH-1:0]   w_step;

    // Bound tests in WIDTH+1 bits so count+STRIDE cannot overflow
    always_comb begin
        w_cnt_x   = {1'b0, r_count};
        w_hi_x    = {1'b0, hi};
        w_lo_x    = {1'b0, lo};
        w_up_sum  = w_cnt_x + LP_STRIDE;
        w_lo_sum  = w_lo_x + LP_STRIDE;
        w_last_up = (w_up_sum > w_hi_x);
        w_last_dn = (w_cnt_x < w_lo_sum);
        w_last    = down ? w_last_dn : w_last_up;
        w_start   = down ? hi : lo;
        w_step    = down ? (r_count - LP_STRIDE[WIDTH-1:0])
                         : w_up_sum[WIDTH-1:0];
    end

    // Count, epoch and wrap pulse: srst > load > en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_epoch <= '0;
            r_wrap  <= 1'b0;
        end else if (srst) begin
            r_count <= w_start;
            r_epoch <= '0;
            r_wrap  <= 1'b0;
        end else if (load) begin
            r_count <= load_val;
            r_wrap  <= 1'b0;
        end else if (en) begin
            if (w_last) begin
                r_count <= w_start;
                r_epoch <= r_epoch + 1'b1;
                r_wrap  <= 1'b1;
            end else begin
                r_count <= w_step;
                r_wrap  <= 1'b0;
            end
        end else begin
            r_wrap  <= 1'b0;
        end
    end

    assign count   = r_count;
    assign epoch   = r_epoch;
    assign phase   = r_epoch[0];
    assign wrap    = r_wrap;
    assign last    = w_last;
    assign cfg_err = (lo > hi);

endmodule

// File: tb/tb_epoch_counter.sv
// tb_epoch_counter: directed checks of epoch_counter
// with unit-stride and stride-3 instances.
module tb_epoch_counter;

    logic       clk;
    logic       rst_n;
    int         n_checks;
    int         n_errors;

    // instance A: WIDTH=4, STRIDE=1, EPOCH_W=2
    logic       a_srst, a_en, a_load, a_down;
    logic [3:0] a_load_val, a_lo, a_hi;
    logic [3:0] a_count;
    logic [1:0] a_epoch;
    logic       a_phase, a_last, a_wrap, a_cfg_err;

    // instance B: WIDTH=4, STRIDE=3, EPOCH_W=1
    logic       b_srst, b_en, b_load, b_down;
    logic [3:0] b_load_val, b_lo, b_hi;
    logic [3:0] b_count;
    logic [0:0] b_epoch;
    logic       b_phase, b_last, b_wrap, b_cfg_err;

    epoch_counter #(.WIDTH(4), .EPOCH_W(2), .STRIDE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .srst(a_srst), .en(a_en),
        .load(a_load), .load_val(a_load_val), .lo(a_lo),
        .hi(a_hi), .down(a_down), .count(a_count),
        .epoch(a_epoch), .phase(a_phase), .last(a_last),
        .wrap(a_wrap), .cfg_err(a_cfg_err)
    );

    epoch_counter #(.WIDTH(4), .EPOCH_W(1), .STRIDE(3)) u_b (
        .clk(clk), .rst_n(rst_n), .srst(b_srst), .en(b_en),
        .load(b_load), .load_val(b_load_val), .lo(b_lo),
        .hi(b_hi), .down(b_down), .count(b_count),
        .epoch(b_epoch), .phase(b_phase), .last(b_last),
        .wrap(b_wrap), .cfg_err(b_cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A: count, epoch, wrap, last in one call
    task automatic chk_a(input string tag,
                         input int c, input int e,
                         input int w, input int l);
        chk({tag, ".count"}, 32'(a_count), 32'(c));
        chk({tag, ".epoch"}, 32'(a_epoch), 32'(e));
        chk({tag, ".phase"}, 32'(a_phase), 32'(e % 2));
        chk({tag, ".wrap"},  32'(a_wrap),  32'(w));
        chk({tag, ".last"},  32'(a_last),  32'(l));
    endtask

    task automatic chk_b(input string tag,
                         input int c, input int e,
                         input int w, input int l);
        chk({tag, ".count"}, 32'(b_count), 32'(c));
        chk({tag, ".epoch"}, 32'(b_epoch), 32'(e));
        chk({tag, ".wrap"},  32'(b_wrap),  32'(w));
        chk({tag, ".last"},  32'(b_last),  32'(l));
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        a_srst     = 1'b0; a_en = 1'b0; a_load = 1'b0;
        a_down     = 1'b0; a_load_val = 4'd0;
        a_lo       = 4'd2; a_hi = 4'd5;
        b_srst     = 1'b0; b_en = 1'b0; b_load = 1'b0;
        b_down     = 1'b0; b_load_val = 4'd0;
        b_lo       = 4'd0; b_hi = 4'd7;

        // reset state
        #3;
        chk_a("rst", 0, 0, 0, 0);
        chk("rst.cfg_err", 32'(a_cfg_err), 32'd0);
        chk_b("rst_b", 0, 0, 0, 0);
        #4;
        rst_n = 1'b1;

        // up count lo=2 hi=5
        a_srst = 1'b1;
        step();
        chk_a("srst", 2, 0, 0, 0);
        a_srst = 1'b0;
        a_en   = 1'b1;
        step();
        chk_a("up3", 3, 0, 0, 0);
        step();
        chk_a("up4", 4, 0, 0, 0);
        step();
        chk_a("up5", 5, 0, 0, 1);
        step();
        chk_a("upwrap", 2, 1, 1, 0);
        step();
        chk_a("up3b", 3, 1, 0, 0);

        // hold for 5 cycles
        a_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_a("hold", 3, 1, 0, 0);
        end

        // load out of range, then wrap to lo
        a_load     = 1'b1;
        a_load_val = 4'd9;
        step();
        chk_a("load9", 9, 1, 0, 1);
        a_load = 1'b0;
        a_en   = 1'b1;
        step();
        chk_a("load9wrap", 2, 2, 1, 0);

        // load beats en while last=1
        a_en   = 1'b0;
        a_load = 1'b1;
        step();
        chk_a("load9b", 9, 2, 0, 1);
        a_en       = 1'b1;
        a_load_val = 4'd7;
        step();
        chk_a("load_en", 7, 2, 0, 1);

        // reach count=4 epoch=3
        a_load = 1'b0;
        step();
        chk_a("wrap3", 2, 3, 1, 0);
        step();
        step();
        chk_a("cnt4", 4, 3, 0, 0);

        // srst beats load and en
        a_srst     = 1'b1;
        a_load     = 1'b1;
        a_load_val = 4'd9;
        step();
        chk_a("srst_all", 2, 0, 0, 0);
        a_srst = 1'b0;
        a_load = 1'b0;
        step();
        step();
        step();
        step();
        chk_a("prerst", 2, 1, 1, 0);

        // async reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        chk_a("async_rst", 0, 0, 0, 0);
        #2;
        rst_n = 1'b1;
        a_en  = 1'b0;

        // down toggle at count=4, lo=0 hi=7
        a_lo       = 4'd0;
        a_hi       = 4'd7;
        a_load     = 1'b1;
        a_load_val = 4'd4;
        step();
        chk_a("ld4", 4, 0, 0, 0);
        a_load = 1'b0;
        a_down = 1'b1;
        a_en   = 1'b1;
        #1;
        chk("dn.last", 32'(a_last), 32'd0);
        step();
        chk_a("dn3", 3, 0, 0, 0);

        // epoch width, lo=hi=0
        a_en   = 1'b0;
        a_down = 1'b0;
        a_hi   = 4'd0;
        a_srst = 1'b1;
        step();
        chk_a("ew_srst", 0, 0, 0, 1);
        a_srst = 1'b0;
        a_en   = 1'b1;
        step();
        chk_a("ew1", 0, 1, 1, 1);
        step();
        chk_a("ew2", 0, 2, 1, 1);
        step();
        chk_a("ew3", 0, 3, 1, 1);
        step();
        chk_a("ew0", 0, 0, 1, 1);
        step();
        chk_a("ew1b", 0, 1, 1, 1);
        a_en = 1'b0;

        // config error
        a_lo = 4'd6;
        a_hi = 4'd2;
        #1;
        chk("cfg_err_hi", 32'(a_cfg_err), 32'd1);
        a_lo = 4'd2;
        #1;
        chk("cfg_err_eq", 32'(a_cfg_err), 32'd0);

        // stride 3 up: 0,3,6,0
        b_srst = 1'b1;
        step();
        chk_b("b_srst", 0, 0, 0, 0);
        b_srst = 1'b0;
        b_en   = 1'b1;
        step();
        chk_b("b_up3", 3, 0, 0, 0);
        step();
        chk_b("b_up6", 6, 0, 0, 1);
        step();
        chk_b("b_upwrap", 0, 1, 1, 0);

        // stride 3 down: 7,4,1,7
        b_en   = 1'b0;
        b_srst = 1'b1;
        b_down = 1'b1;
        step();
        chk_b("b_dsrst", 7, 0, 0, 0);
        b_srst = 1'b0;
        b_en   = 1'b1;
        step();
        chk_b("b_dn4", 4, 0, 0, 0);
        step();
        chk_b("b_dn1", 1, 0, 0, 1);
        step();
        chk_b("b_dnwrap", 7, 1, 1, 0);
        step();
        step();
        chk_b("b_dn1b", 1, 1, 0, 1);
        step();
        chk_b("b_dnwrap2", 7, 0, 1, 0);
        b_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/epoch_counter.md
# epoch_counter

Runtime-programmable wrap-around counter with a multi-bit epoch (wrap) count. Generalises the single-bit phase counter:
- bounds and direction are inputs, not parameters;
- supports a synchronous load;
- counts wraps into an EPOCH_W-bit epoch;
- emits a registered wrap pulse.

Used by the timer, DMA-descriptor and ring-index logic, where bounds are written by CSR at run time and consumers need the wrap parity or the wrap count.

## Interface
- WIDTH, 8, count width in bits
- EPOCH_W, 1, epoch width in bits (≥1); epoch wraps modulo 2^EPOCH_W
- STRIDE, 1, step per enabled cycle; legal range 1 .. 2^WIDTH-1
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- srst  input  1  synchronous clear to start bound
- en  input  1  advance count by STRIDE
- load  input  1  synchronous load of load_val
- load_val  input  WIDTH  value for load
- lo  input  WIDTH  lower bound (inclusive)
- hi  input  WIDTH  upper bound (inclusive)
- down  input  1  0 = count up from lo, 1 = count down from hi
- count  output  WIDTH  current count
- epoch  output  EPOCH_W  number of wraps, modulo 2^EPOCH_W
- phase  output  1  epoch[0]
- last  output  1  next enabled step wraps (combinational)
- wrap  output  1  registered one-cycle pulse after a wrap
- cfg_err  output  1  lo > hi (combinational)

## Operation
- Register update priority, highest first: rst_n, srst, load, en.
- rst_n low:
  - count = 0, epoch = 0, wrap = 0, regardless of lo/hi.
- srst:
  - count ← lo if down = 0; count ← hi if down = 1.
  - epoch ← 0, wrap ← 0.
- load (srst low):
  - count ← load_val; epoch unchanged; wrap ← 0.
  - en ignored that cycle; no wrap occurs.
- en (srst and load low):
  - last = 1: count ← lo (up) or hi (down); epoch ← epoch + 1 (mod 2^EPOCH_W); wrap ← 1.
  - last = 0: count ← count + STRIDE (up) or count − STRIDE (down); wrap ← 0.
- Idle (no srst/load/en): count and epoch hold; wrap ← 0.
- last evaluation, in WIDTH+1 bits with zero extension, no overflow:
  - up: last = (count + STRIDE) > hi
  - down: last = count < (lo + STRIDE)
- Out-of-range count (after load or a bounds change) follows the same formulas:
  - up, count > hi: last = 1; next en wraps to lo.
  - up, count < lo: counts up normally.
  - down, count < lo: last = 1; next en wraps to hi.
- Overshoot: with STRIDE > 1, count never exceeds hi (up) and never goes below lo (down). The final in-range value is the one where last = 1.
- A change of down takes effect immediately on last and on the next step. count is not re-seeded.
- cfg_err = (lo > hi). Counting behaviour is unspecified while cfg_err = 1. Bench checks cfg_err only.

## Timing
- count, epoch, wrap: flops on posedge clk, reset asynchronously.
- phase: wire = epoch[0].
- last and cfg_err: combinational from count, lo, hi, down. Zero latency; valid in the same cycle as the count value.
- wrap: high for exactly the one cycle after the edge on which count wrapped. Consecutive wraps (e.g. lo = hi with en held) keep wrap high continuously.
- Reset values: count 0, epoch 0, phase 0, wrap 0. last and cfg_err follow their inputs.
- Single-cycle throughput: one step per en cycle, no stall.

## Test plan
- **Up count.** WIDTH=4, lo=2, hi=5, STRIDE=1, down=0. Pulse srst, then hold en.
  - count sequence: 2,3,4,5,2.
  - last=1 only while count=5.
  - epoch 0→1 on the wrap edge; wrap=1 in the following cycle only; phase=1.
- **Stride, both directions.** STRIDE=3, lo=0, hi=7.
  - Up: 0,3,6,0 with last at 6.
  - Up with srst and down=1: 7,4,1,7 with last at 1; epoch increments per wrap.
- **Epoch width.** EPOCH_W=2, lo=hi=0, en held.
  - last=1 every cycle; epoch 1,2,3,0,1; phase 1,0,1,0,1.
  - wrap held high from the second cycle on.
- **Load.** hi=5, up.
  - load_val=9: count=9, last=1; next en gives count=lo, epoch+1.
  - load and en in the same cycle with last=1: count=load_val, epoch unchanged, wrap=0.
- **Clears.**
  - srst with en and load high at count=4, epoch=3: count=lo, epoch=0, wrap=0.
  - rst_n asserted mid-cycle: all registers 0 immediately, without waiting for a clock edge.
- **Hold, mode change, config error.**
  - en=0 for 5 cycles: count and epoch stable.
  - Toggle down at count=4 (lo=0, hi=7, STRIDE=1): next en gives 3.
  - lo=6, hi=2: cfg_err=1.
